// File: rtl/serial_alu_ctrl_pkg.sv
// serial_alu_ctrl_pkg: op codes, slice select encodings and FSM states shared by
// the bit-serial ALU sequencer and its decoder.
package serial_alu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;

    localparam logic [1:0] SEL_AND  = 2'b00;
    localparam logic [1:0] SEL_OR   = 2'b10;
    localparam logic [1:0] SEL_SUM  = 2'b01;
    localparam logic [1:0] SEL_LESS = 2'b11;

    function automatic logic op_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/serial_alu_decode.sv
// serial_alu_decode: maps latched op and sequencer state to the 1-bit slice controls.
// Controls are all zero outside RUN/FIX; illegal ops fall back to AND.
module serial_alu_decode
    import serial_alu_ctrl_pkg::*;
(
    input  state_e      state,
    input  logic [2:0]  op,
    output logic        ainvert,
    output logic        binvert,
    output logic [1:0]  operation,
    output logic        cin0,
    output logic        op_err,
    output logic        is_arith,
    output logic        is_slt
);

    logic active;
    logic sub_like;

    always_comb begin
        active    = (state == ST_RUN) || (state == ST_FIX);
        sub_like  = (op == OP_SUB) || (op == OP_SLT);
        op_err    = op_illegal(op);
        is_slt    = (op == OP_SLT);
        is_arith  = (op == OP_ADD) || (op == OP_SUB);
        ainvert   = active & (op == OP_NOR);
        binvert   = active & (sub_like || op == OP_NOR);
        cin0      = active & sub_like;
        operation = !active              ? SEL_AND  :
                    (state == ST_FIX)    ? SEL_LESS :
                    (op == OP_OR)        ? SEL_OR   :
                    (is_arith || is_slt) ? SEL_SUM  : SEL_AND;
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial sequencer driving a 1-bit ALU slice LSB first,
// holding the ripple carry between cycles and assembling the WIDTH-bit result.
module serial_alu_ctrl
    import serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             op_err,
    output logic             s_a,
    output logic             s_b,
    output logic             s_ainvert,
    output logic             s_binvert,
    output logic             s_cin,
    output logic             s_less,
    output logic [1:0]       s_operation,
    input  logic             s_result,
    input  logic             s_cout
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d, set_q, set_d;
    logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d, err_q, err_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             active, ovf_bit;
    logic             dec_cin0, dec_err, dec_arith, dec_slt;

    serial_alu_decode u_dec (
        .state     (state_q),
        .op        (op_q),
        .ainvert   (s_ainvert),
        .binvert   (s_binvert),
        .operation (s_operation),
        .cin0      (dec_cin0),
        .op_err    (dec_err),
        .is_arith  (dec_arith),
        .is_slt    (dec_slt)
    );

    // idx is parked at 0 in FIX, so bit 0 of the operands drives the slice there.
    assign active  = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign s_a     = active & a_q[idx_q];
    assign s_b     = active & b_q[idx_q];
    assign s_cin   = active & ((idx_q == '0) ? dec_cin0 : carry_q);
    assign s_less  = (state_q == ST_FIX) & set_q;
    assign ovf_bit = s_cin ^ s_cout;

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign op_err    = err_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        set_d    = set_q;
        sh_d     = sh_q;
        result_d = result_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a_in;
                    b_d     = b_in;
                    op_d    = op;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                sh_d[idx_q] = s_result;
                carry_d     = s_cout;
                idx_d       = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d = '0;
                    set_d = s_result ^ ovf_bit;
                    if (dec_slt) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d  = ST_DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        result_d = dec_err ? '0 : sh_d;
                        zero_d   = (result_d == '0);
                        cout_d   = dec_arith & s_cout;
                        ovf_d    = dec_arith & ovf_bit;
                        err_d    = dec_err;
                    end
                end
            end
            ST_FIX: begin
                state_d  = ST_DONE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                result_d = {{(WIDTH-1){1'b0}}, s_result};
                zero_d   = !s_result;
                cout_d   = 1'b0;
                ovf_d    = 1'b0;
                err_d    = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            set_q    <= 1'b0;
            sh_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            set_q    <= set_d;
            sh_q     <= sh_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule
